pulse_event_buffer: RTL and testbench
=====================================

# pulse_event_buffer

Downstream stage of the neutron pulse reader. It takes each completed pulse record (start bin, end bin) and computes the pulse width modulo 2^16. Records shorter than a programmable minimum are rejected as glitches; the rest are queued in a small first-word-fall-through FIFO. Readout logic drains the FIFO through a valid/ready handshake, and the block keeps sticky overflow status and saturating drop/reject counters for diagnostics.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, log2(DEPTH); pointer width.
- MIN_WIDTH, 16'd2, records with width < MIN_WIDTH are rejected.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high; one clock; clears everything.
- GLOBAL_STATE  in  3  system state; 3'b000 (sSOFTRESET) acts as a flush.
- EVT_DONE  in  1  one-cycle strobe from upstream reader; STARTBIN/ENDBIN are final in this cycle.
- STARTBIN  in  16  COUNT value at pulse leading edge.
- ENDBIN  in  16  COUNT value at pulse trailing edge.
- RD_READY  in  1  consumer accepts head entry.
- RD_VALID  out  1  FIFO non-empty; head entry presented.
- RD_START  out  16  head entry start bin.
- RD_WIDTH  out  16  head entry width.
- LEVEL  out  AW+1  entries stored, 0..DEPTH.
- FULL  out  1  LEVEL == DEPTH.
- OVERFLOW  out  1  sticky; set when an accepted record is dropped because the FIFO is full.
- DROPPED  out  8  count of records dropped for full; saturates at 255.
- REJECTED  out  8  count of records rejected for short width; saturates at 255.

## Operation
- Width: WIDTH = ENDBIN − STARTBIN, 16-bit modulo; COUNT wrap is handled implicitly (STARTBIN=16'hFFFE, ENDBIN=16'h0003 → 5).
- Per EVT_DONE, exactly one outcome applies, in this priority:
  - WIDTH < MIN_WIDTH: REJECTED += 1 (saturating); nothing written.
  - FIFO not full, or full with a pop in the same cycle: write {STARTBIN, WIDTH} at the write pointer.
  - Otherwise: record dropped; OVERFLOW <= 1; DROPPED += 1 (saturating).
- Pop: occurs when RD_VALID && RD_READY. RD_READY is ignored while RD_VALID = 0.
- Simultaneous push and pop leaves LEVEL unchanged. Both pointers wrap modulo DEPTH.
- Read side is first-word-fall-through: RD_START/RD_WIDTH are the head entry whenever RD_VALID = 1, and are don't-care when RD_VALID = 0.
- Flush: RESET = 1, or GLOBAL_STATE == 3'b000, has the following effect at the next edge:
  - pointers, LEVEL, OVERFLOW, DROPPED and REJECTED all cleared;
  - EVT_DONE and RD_READY in that cycle are ignored.
- Any other GLOBAL_STATE value has no effect on the block.
- Storage contents are not cleared on flush; only pointers and status are.

## Timing
- Reset values: RD_VALID=0, LEVEL=0, FULL=0, OVERFLOW=0, DROPPED=0, REJECTED=0, RD_START/RD_WIDTH don't-care.
- Write latency: EVT_DONE in cycle n into an empty FIFO → RD_VALID=1 and data valid in cycle n+1.
- Pop: handshake in cycle n → the next entry is presented (or RD_VALID falls) in cycle n+1.
- LEVEL, FULL, RD_VALID, OVERFLOW and the counters are registered and update on the same edge as the operation that changes them.
- Empty FIFO with EVT_DONE and RD_READY in the same cycle: no pop, because RD_VALID was 0; LEVEL becomes 1.
- Full FIFO with EVT_DONE and a pop in the same cycle: record accepted, no overflow, LEVEL stays DEPTH.
- Flush has priority over every simultaneous event.
- Back-to-back EVT_DONE on consecutive cycles is supported: one record per cycle.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then a single record (STARTBIN=100, ENDBIN=140), RD_READY=0 → one cycle later RD_VALID=1, RD_START=100, RD_WIDTH=40, LEVEL=1; assert RD_READY one cycle → LEVEL=0, RD_VALID=0.
- Wrap arithmetic: STARTBIN=16'hFFFE, ENDBIN=16'h0003 → RD_WIDTH=5. Glitch: STARTBIN=50, ENDBIN=51 with MIN_WIDTH=2 → REJECTED=1, LEVEL unchanged.
- Fill and overflow (DEPTH=8): push 8 records with RD_READY=0 → FULL=1. Push 3 more → DROPPED=3, OVERFLOW=1. Drain → the original 8 appear in order, then RD_VALID=0.
- Full with simultaneous push and pop → no drop, LEVEL=8; subsequent drain order correct. Empty with simultaneous push and RD_READY → LEVEL=1, entry retained.
- GLOBAL_STATE=3'b000 for one cycle with 5 entries stored, OVERFLOW=1 and an EVT_DONE in the same cycle → next cycle LEVEL=0, RD_VALID=0, OVERFLOW=0, DROPPED=0, REJECTED=0. Repeat the check using RESET.
- Counter saturation: 300 rejected records → REJECTED=255 and stays at 255.

Source files
------------

// File: rtl/pulse_event_buffer_if.sv
// Read-side handshake of the pulse event buffer.
// The slave modport is the buffer side; the master modport is the reader side.
interface pulse_event_buffer_if;
    logic        RD_VALID;
    logic        RD_READY;
    logic [15:0] RD_START;
    logic [15:0] RD_WIDTH;

    modport slave  (output RD_VALID, output RD_START, output RD_WIDTH, input RD_READY);
    modport master (input RD_VALID, input RD_START, input RD_WIDTH, output RD_READY);
endinterface

// File: rtl/pulse_event_buffer.sv
// Pulse record buffer: computes pulse width, rejects glitches, queues records in a
// first-word-fall-through FIFO and keeps sticky overflow plus saturating counters.
module pulse_event_buffer #(
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3,
    parameter logic [15:0] MIN_WIDTH = 16'd2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [2:0]           GLOBAL_STATE,
    input  logic                 EVT_DONE,
    input  logic [15:0]          STARTBIN,
    input  logic [15:0]          ENDBIN,
    pulse_event_buffer_if.slave  rd,
    output logic [AW:0]          LEVEL,
    output logic                 FULL,
    output logic                 OVERFLOW,
    output logic [7:0]           DROPPED,
    output logic [7:0]           REJECTED
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [15:0]   mem_start_q [DEPTH];
    logic [15:0]   mem_width_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    rej_q, rej_d;

    logic [15:0]   width_s;
    logic          flush_s;
    logic          pop_s;
    logic          short_s;
    logic          push_s;
    logic          drop_s;
    logic          wr_en_s;

    // Wrap of the free-running bin counter falls out of the modulo-2^16 subtraction.
    assign width_s = ENDBIN - STARTBIN;
    assign flush_s = RESET || (GLOBAL_STATE == 3'b000);
    assign pop_s   = valid_q && rd.RD_READY;
    assign short_s = EVT_DONE && (width_s < MIN_WIDTH);
    assign push_s  = EVT_DONE && !short_s && (!full_q || pop_s);
    assign drop_s  = EVT_DONE && !short_s && full_q && !pop_s;
    assign wr_en_s = push_s && !flush_s;

    // Next-state for pointers, occupancy and diagnostic status.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        rej_d    = rej_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = 8'd0;
            rej_d    = 8'd0;
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                else                 drop_d = drop_q;
            end else begin
                ovf_d  = ovf_q;
                drop_d = drop_q;
            end
            if (short_s && (rej_q != 8'hFF)) rej_d = rej_q + 8'd1;
            else                             rej_d = rej_q;
        end
        full_d  = (level_d == DEPTH_C);
        valid_d = (level_d != '0);
    end

    // Status and pointer registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
            rej_q    <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            rej_q    <= rej_d;
        end
    end

    // Record storage; contents deliberately survive a flush.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_start_q[wr_ptr_q] <= STARTBIN;
            mem_width_q[wr_ptr_q] <= width_s;
        end
    end

    assign rd.RD_VALID = valid_q;
    assign rd.RD_START = mem_start_q[rd_ptr_q];
    assign rd.RD_WIDTH = mem_width_q[rd_ptr_q];
    assign LEVEL       = level_q;
    assign FULL        = full_q;
    assign OVERFLOW    = ovf_q;
    assign DROPPED     = drop_q;
    assign REJECTED    = rej_q;

endmodule

// File: tb/tb_pulse_event_buffer.sv
// Self-checking bench for pulse_event_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_pulse_event_buffer;

    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam logic [15:0] MINW  = 16'd2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  GS;
    logic        EVT;
    logic [15:0] SB;
    logic [15:0] EB;
    logic [AW:0] LEVEL;
    logic        FULL;
    logic        OVERFLOW;
    logic [7:0]  DROPPED;
    logic [7:0]  REJECTED;

    pulse_event_buffer_if rdif ();

    pulse_event_buffer #(.DEPTH(DEPTH), .AW(AW), .MIN_WIDTH(MINW)) dut (
        .CLK(CLK), .RESET(RESET), .GLOBAL_STATE(GS), .EVT_DONE(EVT),
        .STARTBIN(SB), .ENDBIN(EB), .rd(rdif),
        .LEVEL(LEVEL), .FULL(FULL), .OVERFLOW(OVERFLOW),
        .DROPPED(DROPPED), .REJECTED(REJECTED)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queue of {start, width}.
    logic [31:0] mq[$];
    int          m_rej;
    int          m_drop;
    bit          m_ovf;

    task automatic drive(bit e, logic [15:0] s, logic [15:0] en, bit r);
        EVT = e; SB = s; EB = en; rdif.RD_READY = r;
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        logic [15:0] w;
        bit popped;
        bit do_push;
        if (RESET || GS == 3'b000) begin
            mq.delete(); m_rej = 0; m_drop = 0; m_ovf = 0;
        end else begin
            popped  = (mq.size() > 0) && rdif.RD_READY;
            w       = EB - SB;
            do_push = 0;
            if (EVT) begin
                if (w < MINW) begin
                    if (m_rej < 255) m_rej++;
                end else if (mq.size() < DEPTH || popped) begin
                    do_push = 1;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (popped) void'(mq.pop_front());
            if (do_push) mq.push_back({SB, w});
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; drive(0, 16'd0, 16'd0, 0);
        tick();
        RESET = 1'b0;
    endtask

    task automatic push_n(int n);
        logic [15:0] s;
        for (int i = 0; i < n; i++) begin
            s = 16'($urandom);
            drive(1, s, s + 16'($urandom_range(2, 1000)), 0);
            tick();
        end
        drive(0, 16'd0, 16'd0, 0);
    endtask

    task automatic test_reset();
        GS = 3'b010;
        do_reset();
        n_checks++; if (rdif.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rdif.RD_VALID); end
        n_checks++; if (LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", LEVEL); end
        n_checks++; if (FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", FULL); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", OVERFLOW); end
        n_checks++; if (DROPPED !== 8'd0 || REJECTED !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", DROPPED, REJECTED); end
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 16'd100, 16'd140, 0); tick(); drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (rdif.RD_VALID !== 1'b1 || LEVEL !== 4'd1) begin n_fail++; $display("FAIL single_valid: got v=%b l=%0d expected v=1 l=1", rdif.RD_VALID, LEVEL); end
        n_checks++; if (rdif.RD_START !== 16'd100 || rdif.RD_WIDTH !== 16'd40) begin n_fail++; $display("FAIL single_data: got %0d/%0d expected 100/40", rdif.RD_START, rdif.RD_WIDTH); end
        drive(0, 16'd0, 16'd0, 1); tick(); drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (rdif.RD_VALID !== 1'b0 || LEVEL !== 4'd0) begin n_fail++; $display("FAIL single_pop: got v=%b l=%0d expected v=0 l=0", rdif.RD_VALID, LEVEL); end
    endtask

    task automatic test_wrap_glitch();
        do_reset();
        drive(1, 16'hFFFE, 16'h0003, 0); tick();
        n_checks++; if (rdif.RD_WIDTH !== 16'd5 || rdif.RD_START !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_width: got %h/%0d expected fffe/5", rdif.RD_START, rdif.RD_WIDTH); end
        drive(1, 16'd50, 16'd51, 0); tick(); drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (REJECTED !== 8'd1 || LEVEL !== 4'd1) begin n_fail++; $display("FAIL glitch: got rej=%0d l=%0d expected 1/1", REJECTED, LEVEL); end
        n_checks++; if (rdif.RD_WIDTH !== 16'd5) begin n_fail++; $display("FAIL glitch_head: got %0d expected 5", rdif.RD_WIDTH); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        push_n(DEPTH);
        n_checks++; if (FULL !== 1'b1 || LEVEL !== 4'd8) begin n_fail++; $display("FAIL fill_full: got f=%b l=%0d expected 1/8", FULL, LEVEL); end
        push_n(3);
        n_checks++; if (DROPPED !== 8'd3 || OVERFLOW !== 1'b1 || LEVEL !== 4'd8) begin n_fail++; $display("FAIL overflow: got d=%0d o=%b l=%0d expected 3/1/8", DROPPED, OVERFLOW, LEVEL); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (rdif.RD_VALID !== 1'b1 || {rdif.RD_START, rdif.RD_WIDTH} !== mq[0]) begin n_fail++; $display("FAIL drain_%0d: got v=%b %h expected %h", i, rdif.RD_VALID, {rdif.RD_START, rdif.RD_WIDTH}, mq[0]); end
            drive(0, 16'd0, 16'd0, 1); tick();
        end
        drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (rdif.RD_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL drain_end: got v=%b o=%b expected 0/1", rdif.RD_VALID, OVERFLOW); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] first;
        do_reset();
        push_n(DEPTH);
        first = mq[0];
        drive(1, 16'd7000, 16'd7123, 1); tick(); drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (LEVEL !== 4'd8 || DROPPED !== 8'd0 || OVERFLOW !== 1'b0 || FULL !== 1'b1) begin n_fail++; $display("FAIL full_pushpop: got l=%0d d=%0d o=%b f=%b expected 8/0/0/1", LEVEL, DROPPED, OVERFLOW, FULL); end
        n_checks++; if ({rdif.RD_START, rdif.RD_WIDTH} === first) begin n_fail++; $display("FAIL full_pushpop_head: got %h expected head advanced past it", first); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (rdif.RD_VALID !== 1'b1 || {rdif.RD_START, rdif.RD_WIDTH} !== mq[0]) begin n_fail++; $display("FAIL pp_drain_%0d: got %h expected %h", i, {rdif.RD_START, rdif.RD_WIDTH}, mq[0]); end
            drive(0, 16'd0, 16'd0, 1); tick();
        end
        drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (rdif.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b expected 0", rdif.RD_VALID); end
    endtask

    task automatic test_empty_push_ready();
        do_reset();
        drive(1, 16'd300, 16'd333, 1); tick(); drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (LEVEL !== 4'd1 || rdif.RD_VALID !== 1'b1) begin n_fail++; $display("FAIL empty_pushrdy: got l=%0d v=%b expected 1/1", LEVEL, rdif.RD_VALID); end
        n_checks++; if (rdif.RD_START !== 16'd300 || rdif.RD_WIDTH !== 16'd33) begin n_fail++; $display("FAIL empty_pushrdy_data: got %0d/%0d expected 300/33", rdif.RD_START, rdif.RD_WIDTH); end
    endtask

    task automatic test_flush();
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            push_n(DEPTH + 1);
            drive(1, 16'd50, 16'd51, 0); tick();
            for (int i = 0; i < 3; i++) begin drive(0, 16'd0, 16'd0, 1); tick(); end
            n_checks++; if (LEVEL !== 4'd5 || OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL flush%0d_pre: got l=%0d o=%b expected 5/1", mode, LEVEL, OVERFLOW); end
            if (mode == 0) GS = 3'b000; else RESET = 1'b1;
            drive(1, 16'd7, 16'd100, 1); tick();
            GS = 3'b011; RESET = 1'b0; drive(0, 16'd0, 16'd0, 0);
            n_checks++; if (LEVEL !== 4'd0 || rdif.RD_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL flush%0d_state: got l=%0d v=%b o=%b expected 0/0/0", mode, LEVEL, rdif.RD_VALID, OVERFLOW); end
            n_checks++; if (DROPPED !== 8'd0 || REJECTED !== 8'd0) begin n_fail++; $display("FAIL flush%0d_cnt: got %0d/%0d expected 0/0", mode, DROPPED, REJECTED); end
            drive(1, 16'd20, 16'd29, 0); tick(); drive(0, 16'd0, 16'd0, 0);
            n_checks++; if (LEVEL !== 4'd1 || rdif.RD_START !== 16'd20 || rdif.RD_WIDTH !== 16'd9) begin n_fail++; $display("FAIL flush%0d_after: got l=%0d %0d/%0d expected 1 20/9", mode, LEVEL, rdif.RD_START, rdif.RD_WIDTH); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] s;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            s = 16'($urandom);
            drive(1, s, s + 16'($urandom_range(0, 1)), 0); tick();
            if (i == 253) begin
                n_checks++; if (REJECTED !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", REJECTED); end
            end
        end
        n_checks++; if (REJECTED !== 8'd255 || LEVEL !== 4'd0) begin n_fail++; $display("FAIL sat_255: got rej=%0d l=%0d expected 255/0", REJECTED, LEVEL); end
        drive(1, 16'd9, 16'd9, 0); tick(); drive(0, 16'd0, 16'd0, 0);
        n_checks++; if (REJECTED !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", REJECTED); end
    endtask

    task automatic test_random();
        logic [15:0] s;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            GS    = ($urandom_range(99, 0) == 0) ? 3'b000 : 3'($urandom_range(7, 1));
            RESET = ($urandom_range(199, 0) == 0);
            s     = 16'($urandom);
            if ($urandom_range(4, 0) == 0) drive($urandom_range(9, 0) < 6, s, s + 16'($urandom_range(0, 1)), $urandom_range(1, 0) == 1);
            else                           drive($urandom_range(9, 0) < 6, s, 16'($urandom), $urandom_range(2, 0) == 0);
            tick();
            n_checks++; if (LEVEL !== 4'(mq.size()) || FULL !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d/%b expected %0d", c, LEVEL, FULL, mq.size()); end
            n_checks++; if (rdif.RD_VALID !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, rdif.RD_VALID, mq.size() != 0); end
            n_checks++; if (OVERFLOW !== m_ovf || DROPPED !== 8'(m_drop) || REJECTED !== 8'(m_rej)) begin n_fail++; $display("FAIL rnd_status c%0d: got %b/%0d/%0d expected %b/%0d/%0d", c, OVERFLOW, DROPPED, REJECTED, m_ovf, m_drop, m_rej); end
            if (mq.size() != 0) begin
                n_checks++; if ({rdif.RD_START, rdif.RD_WIDTH} !== mq[0]) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", c, {rdif.RD_START, rdif.RD_WIDTH}, mq[0]); end
            end
        end
        GS = 3'b010; RESET = 1'b0; drive(0, 16'd0, 16'd0, 0);
    endtask

    initial begin
        RESET = 1'b0; GS = 3'b010;
        drive(0, 16'd0, 16'd0, 0);
        @(posedge CLK); #1;
        test_reset();
        test_single();
        test_wrap_glitch();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_ready();
        test_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
